// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue, held in pending registers, and committed after the op latency.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             o_dbg_state
);

    localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam int W2     = 2 * WIDTH;
    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_done;

    // Issue handshake: start is the valid, "not busy" the ready; an op is taken on a
    // rising edge where start=1, abort=0 and busy=0, and is otherwise dropped.
    logic w_accept;
    logic w_complete;
    logic w_is_mul;
    logic w_is_div;
    logic w_is_acc;
    logic w_is_multi;

    assign w_accept   = start & ~abort & (r_state == S_IDLE);
    assign w_is_mul   = (op == 4'd1) | (op == 4'd2);
    assign w_is_div   = (op == 4'd3) | (op == 4'd4);
    assign w_is_acc   = (op >= 4'd9) & (op <= 4'd12);
    assign w_is_multi = w_is_mul | w_is_div | w_is_acc;

    // Multiplier: sign- or zero-extend to 2W so one unsigned 2W multiply serves both.
    logic          w_mul_signed;
    logic [W2-1:0] w_ma;
    logic [W2-1:0] w_mb;
    logic [W2-1:0] w_prod;
    logic [W2-1:0] w_acc;
    logic [W2-1:0] w_madd;
    logic [W2-1:0] w_msub;

    assign w_mul_signed = (op == 4'd1) | (op == 4'd9) | (op == 4'd11);
    assign w_ma   = w_mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_mb   = w_mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign w_prod = w_ma * w_mb;
    assign w_acc  = {r_hi, r_lo};
    assign w_madd = w_acc + w_prod;
    assign w_msub = w_acc - w_prod;

    // Divider: signed divide runs on magnitudes; MIN/-1 falls out as lo=MIN, hi=0.
    logic             w_div_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    assign w_div_signed = (op == 4'd3);
    assign w_a_neg      = w_div_signed & a[WIDTH-1];
    assign w_b_neg      = w_div_signed & b[WIDTH-1];
    assign w_div_zero   = (b == '0);
    assign w_a_mag      = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag      = w_b_neg ? (~b + 1'b1) : b;
    assign w_uq         = w_div_zero ? '0 : (w_a_mag / w_b_mag);
    assign w_ur         = w_div_zero ? '0 : (w_a_mag % w_b_mag);
    assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_uq + 1'b1) : w_uq;
    assign w_r          = w_a_neg ? (~w_ur + 1'b1) : w_ur;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [CW-1:0]    w_lat;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_lat    = MULT_LAT;
        case (op)
            4'd1, 4'd2: {w_res_hi, w_res_lo} = w_prod;
            4'd3, 4'd4: begin
                w_lat = DIV_LAT;
                if (w_div_zero) begin
                    w_res_hi = a;
                    w_res_lo = '1;
                end else begin
                    w_res_hi = w_r;
                    w_res_lo = w_q;
                end
            end
            4'd9, 4'd10:  {w_res_hi, w_res_lo} = w_madd;
            4'd11, 4'd12: {w_res_hi, w_res_lo} = w_msub;
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && w_is_multi) w_next_state = S_RUN;
            S_RUN: begin
                if (r_count == CW'(1)) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept && w_is_multi) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_count   <= w_lat;
            end else if (r_state == S_RUN) begin
                r_count <= r_count - CW'(1);
            end
            // Commit has priority, though mthi/mtlo cannot be accepted while running.
            if (w_complete) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_accept && op == 4'd7) begin
                r_hi <= a;
            end else if (w_accept && op == 4'd8) begin
                r_lo <= a;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign rd_data     = (op == 4'd5) ? r_hi : (op == 4'd6) ? r_lo : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed corner cases plus randomized ops
// compared against an arithmetic model of HI/LO.
module tb_mdu_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        dbg_state;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_tests;
  int          n_fail;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .rd_data(rd_data), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] o);
    if (o == 4'd3 || o == 4'd4) return 10;
    if (o == 4'd1 || o == 4'd2 || (o >= 4'd9 && o <= 4'd12)) return 5;
    return 0;
  endfunction

  // Reference model: architectural effect of one accepted op on HI/LO.
  task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    longint      sp;
    longint      q;
    longint      r;
    logic [63:0] up;
    logic [63:0] acc;
    sx  = x;
    sy  = y;
    sp  = longint'(sx) * longint'(sy);
    up  = {32'b0, x} * {32'b0, y};
    acc = {m_hi, m_lo};
    case (o)
      4'd1: {m_hi, m_lo} = 64'(sp);
      4'd2: {m_hi, m_lo} = up;
      4'd3, 4'd4: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = x;
        end else if (o == 4'd3) begin
          q    = longint'(sx) / longint'(sy);
          r    = longint'(sx) % longint'(sy);
          m_lo = 32'(q);
          m_hi = 32'(r);
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      4'd7:  m_hi = x;
      4'd8:  m_lo = x;
      4'd9:  {m_hi, m_lo} = acc + 64'(sp);
      4'd10: {m_hi, m_lo} = acc + up;
      4'd11: {m_hi, m_lo} = acc - 64'(sp);
      4'd12: {m_hi, m_lo} = acc - up;
      default: ;
    endcase
  endtask

  // Driver: issue one op, follow it to completion, compare against the model.
  // probe=1 also reads LO and fires an ignored start while the op is running.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit ab, input bit probe);
    logic [31:0] old_lo;
    logic [31:0] exp_rd;
    int          lat;
    int          cyc;
    int          dn;
    lat    = ab ? 0 : lat_of(o);
    old_lo = m_lo;
    exp_rd = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; abort = ab;
    #1;
    check("rd_data", 64'(rd_data), 64'(exp_rd));
    if (!ab) model_op(o, x, y);
    @(negedge clk);
    start = 1'b0; op = 4'd0; abort = 1'b0;
    if (lat > 0) begin
      cyc = 0;
      dn  = 0;
      while (busy && cyc < 200) begin
        if (done) dn++;
        if (probe && cyc == 1) begin
          op = 4'd6;
          #1;
          check("mflo_in_run", 64'(rd_data), 64'(old_lo));
          start = 1'b1; op = 4'd2; a = $urandom; b = $urandom;
        end else if (probe && cyc == 2) begin
          start = 1'b0; op = 4'd0;
        end
        cyc++;
        @(negedge clk);
      end
      check("busy_cycles", 64'(cyc), 64'(lat));
      check("done_during_busy", 64'(dn), 64'd0);
      check("done_pulse", 64'(done), 64'd1);
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
      check("done_clear", 64'(done), 64'd0);
      check("busy_after", 64'(busy), 64'd0);
    end else begin
      check("busy_single", 64'(busy), 64'd0);
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    n_tests = 0;
    n_fail  = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 4'd0;
    a       = 32'd0;
    b       = 32'd0;
    abort   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div0_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(4'd9, 32'd1, 32'd1, 1'b0, 1'b0);
    check("madd_const", {hi, lo}, 64'h0000_0001_0000_0000);
    run_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd12, 32'd1, 32'd1, 1'b0, 1'b0);
    check("msubu_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(4'd7, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    check("abort_mthi", 64'(hi), 64'hFFFF_FFFF);
    run_op(4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    run_op(4'd4, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op(4'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), rand_val(), rand_val(),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a divide.
    run_op(4'd8, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 4'd3; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done_after_rst", 64'(dn), 64'd0);
    check("hilo_after_rst", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
